// File: rtl/taus_pkg.sv
// Shared definitions for the combined Tausworthe generator output stage.
//   taus_comb_state_t : control state of the combiner (idle / warm-up / run)
//   TAUS_W            : width of every generator word
package taus_pkg;

  localparam int TAUS_W = 32;

  typedef enum logic [1:0] {
    TAUS_IDLE   = 2'd0,
    TAUS_WARMUP = 2'd1,
    TAUS_RUN    = 2'd2
  } taus_comb_state_t;

endpackage

// File: rtl/taus_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (pointers only)
//   push, din         : write request and data; a push into a full FIFO is
//                       accepted only when a pop happens in the same cycle
//   pop               : read request; ignored while empty
//   dout              : head word, forced to 0 while empty
//   full, empty, count: occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module taus_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok;
  logic         pop_ok;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count   = wr_ptr_q - rd_ptr_q;
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; a stale slot is never visible because dout is
  // masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/taus_combiner.sv
// Output stage of the combined Tausworthe generator.
// XORs the three free-running component words every cycle, discards WARMUP
// samples after each enable, then pushes samples into a FWFT FIFO that is
// drained over a valid/ready handshake. Samples arriving while the FIFO is
// full are dropped (the generators never stall).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   en                : level enable (low returns to IDLE, FIFO kept)
//   s1, s2, s3        : component generator words
//   out_data/out_valid/out_ready : downstream handshake
//   busy              : registered, high in WARMUP or RUN
//   words_out         : saturating delivered-word counter, present only when
//                       the TAUS_COMB_STATS_EN macro is defined
module taus_combiner
  import taus_pkg::*;
#(
  parameter int WARMUP = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [TAUS_W-1:0] s1,
  input  logic [TAUS_W-1:0] s2,
  input  logic [TAUS_W-1:0] s3,
  output logic [TAUS_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef TAUS_COMB_STATS_EN
  ,
  output logic [TAUS_W-1:0] words_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CW-1:0] WARM_LOAD = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

  taus_comb_state_t  state_q, state_d;
  logic [CW-1:0]     warm_cnt_q, warm_cnt_d;
  logic              busy_q, busy_d;
  logic [TAUS_W-1:0] sample;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;

  always_comb begin
    sample     = s1 ^ s2 ^ s3;
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      TAUS_IDLE: begin
        if (en) begin
          if (WARMUP == 0) begin
            state_d = TAUS_RUN;
          end else begin
            state_d    = TAUS_WARMUP;
            warm_cnt_d = WARM_LOAD;
          end
        end
      end
      TAUS_WARMUP: begin
        // Dropping en wins over an expiring counter.
        if (!en) begin
          state_d = TAUS_IDLE;
        end else if (warm_cnt_q == '0) begin
          state_d = TAUS_RUN;
        end else begin
          warm_cnt_d = warm_cnt_q - 1'b1;
        end
      end
      TAUS_RUN: begin
        if (!en) begin
          state_d = TAUS_IDLE;
        end
      end
      default: begin
        state_d = TAUS_IDLE;
      end
    endcase
    busy_d = (state_d != TAUS_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TAUS_IDLE;
      warm_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  always_comb begin
    pop  = out_valid && out_ready;
    push = (state_q == TAUS_RUN) && en &&
           ((fifo_count < DEPTH_C) || (fifo_full && pop));
  end

  taus_fifo #(
    .W     (TAUS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sample),
    .pop   (pop),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign busy      = busy_q;

`ifdef TAUS_COMB_STATS_EN
  logic [TAUS_W-1:0] words_out_q, words_out_d;

  always_comb begin
    words_out_d = words_out_q;
    if (pop && (words_out_q != '1)) begin
      words_out_d = words_out_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_out_q <= '0;
    end else begin
      words_out_q <= words_out_d;
    end
  end

  assign words_out = words_out_q;
`endif

endmodule

// File: tb/tb_taus_combiner.sv
module tb_taus_combiner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] s1, s2, s3;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef TAUS_COMB_STATS_EN
  logic [31:0] words_out;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit count_mode = 1'b0;

  taus_combiner #(
    .WARMUP (3),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef TAUS_COMB_STATS_EN
    ,
    .words_out (words_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle: sample/drive point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (count_mode) s1 = s1 + 32'd1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    s1 = 32'd0; s2 = 32'd0; s3 = 32'd0;
    repeat (2) tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("idle_data", out_data, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Warm-up of 3 with constant words 1,2,4: first word 7 after the 5th edge.
    s1 = 32'd1; s2 = 32'd2; s3 = 32'd4; out_ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("wu_busy", {31'd0, busy}, 32'd1);
      check("wu_valid", {31'd0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("wu_data", out_data, 32'd7);
    en = 1'b0;
    repeat (4) tick();
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_valid", {31'd0, out_valid}, 32'd0);

    // Counting s1, no readiness: FIFO keeps 104..107, later samples dropped.
    s1 = 32'd100; s2 = 32'd0; s3 = 32'd0; out_ready = 1'b0;
    count_mode = 1'b1; en = 1'b1;
    repeat (8) tick();
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_head8", out_data, 32'd104);
    repeat (3) tick();
    check("full_head11", out_data, 32'd104);
    // One handshake while full: 104 leaves and sample 111 enters.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_valid", {31'd0, out_valid}, 32'd1);
    check("pp_head", out_data, 32'd105);
    repeat (2) tick();
    check("hold_head", out_data, 32'd105);
    out_ready = 1'b1;
    begin
      logic [31:0] exp_seq [6];
      exp_seq = '{32'd106, 32'd107, 32'd111, 32'd114, 32'd115, 32'd116};
      for (int k = 0; k < 6; k++) begin
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd1);
        check("drain_data", out_data, exp_seq[k]);
      end
    end

    // Reset mid-warm-up.
    en = 1'b0;
    repeat (6) tick();
    check("pre_wu_valid", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    repeat (2) tick();
    check("mid_wu_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rst_wu_busy", {31'd0, busy}, 32'd0);
    check("rst_wu_valid", {31'd0, out_valid}, 32'd0);
    // Re-enable: full warm-up again, first word is the cycle-4 sample.
    out_ready = 1'b0;
    s1 = 32'd200;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("re_valid", {31'd0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("re_data", out_data, 32'd204);
    repeat (4) tick();
    check("re_full_head", out_data, 32'd204);

    // Reset with a full FIFO.
    rst = 1'b1;
    tick();
    check("rstf_valid", {31'd0, out_valid}, 32'd0);
    check("rstf_data", out_data, 32'd0);
    check("rstf_busy", {31'd0, busy}, 32'd0);
    en = 1'b0;
    rst = 1'b0;
    tick();
    check("rstf_idle", {31'd0, out_valid}, 32'd0);

`ifdef TAUS_COMB_STATS_EN
    check("st_zero", words_out, 32'd0);
    out_ready = 1'b1; en = 1'b1;
    repeat (14) tick();
    en = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();
    check("st_ten", words_out, 32'd10);
    force dut.words_out_q = 32'hFFFF_FFFE;
    #1;
    release dut.words_out_q;
    out_ready = 1'b1; en = 1'b1;
    repeat (10) tick();
    check("st_sat", words_out, 32'hFFFF_FFFF);
    en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
